// File: rtl/player_mover_pkg.sv
// Shared constants for the game controller: direction codes, grid geometry,
// colour codes and the player_mover state encoding.
package player_mover_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam int TILE   = 5;
  localparam int GRID_W = 32;
  localparam int GRID_H = 24;

  localparam logic [2:0] COL_WALL   = 3'b111;
  localparam logic [2:0] COL_TRAP   = 3'b100;
  localparam logic [2:0] COL_GOAL   = 3'b010;
  localparam logic [2:0] COL_EMPTY  = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT1,
    ST_WAIT2,
    ST_DECIDE,
    ST_ERASE,
    ST_MOVE,
    ST_DRAW
  } state_e;

  // Only a single pressed key counts as a direction; chords and no-key give 0.
  function automatic logic [3:0] valid_dir(input logic [3:0] keys);
    case (keys)
      DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: valid_dir = keys;
      default:                               valid_dir = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/player_mover_sprite_counter.sv
// Row-major 5x5 pixel scan (cx fastest) shared by the sprite erase and draw passes.
module sprite_counter
  import player_mover_pkg::*;
#(
  parameter int SPRITE = TILE
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       clear,
  output logic [2:0] cx,
  output logic [2:0] cy,
  output logic       done
);

  localparam logic [2:0] LAST = 3'(SPRITE - 1);

  logic [2:0] cx_q, cx_d;
  logic [2:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (start) begin
      if (cx_q == LAST) begin
        cx_d = '0;
        cy_d = (cy_q == LAST) ? 3'd0 : cy_q + 3'd1;
      end else begin
        cx_d = cx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign done = start && !clear && (cx_q == LAST) && (cy_q == LAST);

endmodule

// File: rtl/player_mover.sv
// Player movement stage: latches a one-hot key per frame, waits for the
// controller's stop verdict, then erases, moves and redraws the 5x5 sprite.
module player_mover
  import player_mover_pkg::*;
#(
  parameter logic [7:0] START_X    = 8'd75,
  parameter logic [6:0] START_Y    = 7'd100,
  parameter int         SPRITE     = TILE,
  parameter logic [7:0] MAX_X      = 8'(GRID_W * TILE - TILE),
  parameter logic [6:0] MAX_Y      = 7'(GRID_H * TILE - TILE),
  parameter logic [2:0] PLAYER_COL = COL_PLAYER,
  parameter logic [2:0] BG_COL     = COL_EMPTY
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       respawn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [3:0] key_dir,
  input  logic       stop,
  output logic [3:0] direction,
  output logic [7:0] player_x,
  output logic [6:0] player_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [7:0] px_q, px_d;
  logic [6:0] py_q, py_d;
  logic       need_draw_q, need_draw_d;

  logic [3:0] direction_q;
  logic [7:0] x_out_q;
  logic [6:0] y_out_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       busy_q;

  logic [2:0] cx, cy;
  logic       scan_done;
  logic       scanning;
  logic       blocked;

  assign scanning = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  sprite_counter #(.SPRITE(SPRITE)) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (scanning),
    .clear  (respawn || !scanning),
    .cx     (cx),
    .cy     (cy),
    .done   (scan_done)
  );

  // A step that would leave the playfield is refused before anything is erased.
  always_comb begin
    blocked = 1'b1;
    case (dir_q)
      DIR_UP:    blocked = (py_q == 7'd0);
      DIR_DOWN:  blocked = (py_q >= MAX_Y);
      DIR_LEFT:  blocked = (px_q == 8'd0);
      DIR_RIGHT: blocked = (px_q >= MAX_X);
      default:   blocked = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    px_d        = px_q;
    py_d        = py_q;
    need_draw_d = need_draw_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && need_draw_q) begin
          state_d = ST_DRAW;
        end else if (enable && frame_tick) begin
          dir_d   = valid_dir(key_dir);
          state_d = ST_WAIT1;
        end
      end
      ST_WAIT1:  state_d = ST_WAIT2;
      ST_WAIT2:  state_d = ST_DECIDE;
      ST_DECIDE: state_d = (stop || blocked) ? ST_IDLE : ST_ERASE;
      ST_ERASE:  if (scan_done) state_d = ST_MOVE;
      ST_MOVE: begin
        case (dir_q)
          DIR_UP:    py_d = py_q - 7'd1;
          DIR_DOWN:  py_d = py_q + 7'd1;
          DIR_LEFT:  px_d = px_q - 8'd1;
          DIR_RIGHT: px_d = px_q + 8'd1;
          default:   ;
        endcase
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (scan_done) begin
          need_draw_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so each lags the state by one clock.
  always_ff @(posedge clock) begin
    if (!resetn || respawn) begin
      state_q     <= ST_IDLE;
      dir_q       <= '0;
      px_q        <= START_X;
      py_q        <= START_Y;
      need_draw_q <= 1'b1;
      direction_q <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      px_q        <= px_d;
      py_q        <= py_d;
      need_draw_q <= need_draw_d;
      direction_q <= (state_q == ST_IDLE || state_q == ST_DRAW) ? 4'b0000 : dir_q;
      plot_q      <= scanning;
      busy_q      <= (state_q != ST_IDLE);
      if (scanning) begin
        x_out_q  <= px_q + {5'd0, cx};
        y_out_q  <= py_q + {4'd0, cy};
        colour_q <= (state_q == ST_ERASE) ? BG_COL : PLAYER_COL;
      end
    end
  end

  assign direction = direction_q;
  assign player_x  = px_q;
  assign player_y  = py_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: vector table of single moves plus
// hand-written sequences for startup draw, playfield edges, respawn and enable.
module tb_player_mover;
  import player_mover_pkg::*;

  logic       clock = 1'b0;
  logic       resetn, respawn, enable, frame_tick, stop;
  logic [3:0] key_dir;
  logic [3:0] direction;
  logic [7:0] player_x, x_out;
  logic [6:0] player_y, y_out;
  logic [2:0] colour;
  logic       plot, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_x, exp_y;

  player_mover dut (
    .clock      (clock),
    .resetn     (resetn),
    .respawn    (respawn),
    .enable     (enable),
    .frame_tick (frame_tick),
    .key_dir    (key_dir),
    .stop       (stop),
    .direction  (direction),
    .player_x   (player_x),
    .player_y   (player_y),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] key;
    logic       stop_v;
    logic [3:0] exp_dir;
    logic       exp_move;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // One frame tick and 60 cycles of observation; T is the edge that accepts the tick.
  task automatic run_move(input logic [3:0] key, input logic stop_v, input logic [3:0] exp_dir,
                          input logic exp_move, input int retick_k, input string name);
    int nx, ny, last_dir, last_busy, idx, bx, by, nplot;
    int dir_err, busy_err, pix_err, pos_err;
    logic [3:0] e_dir;
    logic e_busy, e_plot;
    logic [2:0] e_col;
    nx = exp_x; ny = exp_y;
    if (exp_move) begin
      case (exp_dir)
        DIR_UP:    ny = exp_y - 1;
        DIR_DOWN:  ny = exp_y + 1;
        DIR_LEFT:  nx = exp_x - 1;
        DIR_RIGHT: nx = exp_x + 1;
        default:   ;
      endcase
    end
    last_dir  = exp_move ? 29 : 3;
    last_busy = exp_move ? 54 : 3;
    nplot = 0; dir_err = 0; busy_err = 0; pix_err = 0; pos_err = 0;
    @(negedge clock);
    key_dir = key; stop = stop_v; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    key_dir = 4'b0110;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      e_dir  = (k <= last_dir) ? exp_dir : 4'b0000;
      e_busy = (k <= last_busy);
      e_plot = exp_move && ((k >= 4 && k <= 28) || (k >= 30 && k <= 54));
      if (direction !== e_dir) dir_err++;
      if (busy !== e_busy) busy_err++;
      if (plot !== e_plot) pix_err++;
      else if (e_plot) begin
        idx   = (k <= 28) ? k - 4 : k - 30;
        bx    = (k <= 28) ? exp_x : nx;
        by    = (k <= 28) ? exp_y : ny;
        e_col = (k <= 28) ? 3'b000 : 3'b001;
        if (int'(x_out) != bx + idx % 5 || int'(y_out) != by + idx / 5 || colour !== e_col)
          pix_err++;
      end
      if (plot === 1'b1) nplot++;
      if (int'(player_x) != ((k >= 29) ? nx : exp_x) || int'(player_y) != ((k >= 29) ? ny : exp_y))
        pos_err++;
      frame_tick = (k == retick_k);
    end
    frame_tick = 1'b0;
    check({name, " direction"}, dir_err, 0);
    check({name, " busy"}, busy_err, 0);
    check({name, " pixels"}, pix_err, 0);
    check({name, " plot_count"}, nplot, exp_move ? 50 : 0);
    check({name, " position"}, pos_err, 0);
    $display("move %-14s key=%b stop=%b pos=(%0d,%0d) plots=%0d", name, key, stop_v,
             player_x, player_y, nplot);
    exp_x = nx; exp_y = ny;
  endtask

  // Collects a full sprite draw expected to start within the next few cycles.
  task automatic check_draw(input string name, input int bx, input int by);
    int nplot, nbusy, pix_err;
    nplot = 0; nbusy = 0; pix_err = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (plot === 1'b1) begin
        if (int'(x_out) != bx + nplot % 5 || int'(y_out) != by + nplot / 5 || colour !== 3'b001)
          pix_err++;
        nplot++;
      end
      if (busy === 1'b1) nbusy++;
    end
    check({name, " plot_count"}, nplot, 25);
    check({name, " busy_cycles"}, nbusy, 25);
    check({name, " pixels"}, pix_err, 0);
    check({name, " player_x"}, int'(player_x), bx);
    check({name, " player_y"}, int'(player_y), by);
    $display("draw %-14s at (%0d,%0d) plots=%0d busy=%0d", name, bx, by, nplot, nbusy);
  endtask

  initial begin
    int nbusy;
    vecs[0] = '{DIR_RIGHT, 1'b0, DIR_RIGHT, 1'b1, "right"};
    vecs[1] = '{DIR_UP,    1'b1, DIR_UP,    1'b0, "up_stopped"};
    vecs[2] = '{4'b1010,   1'b0, 4'b0000,   1'b0, "two_keys"};
    vecs[3] = '{DIR_LEFT,  1'b0, DIR_LEFT,  1'b1, "left"};
    vecs[4] = '{DIR_DOWN,  1'b0, DIR_DOWN,  1'b1, "down"};
    vecs[5] = '{DIR_UP,    1'b0, DIR_UP,    1'b1, "up"};
    vecs[6] = '{4'b0000,   1'b0, 4'b0000,   1'b0, "no_key"};
    vecs[7] = '{4'b1111,   1'b0, 4'b0000,   1'b0, "all_keys"};

    resetn = 1'b0; respawn = 1'b0; enable = 1'b0; frame_tick = 1'b0;
    stop = 1'b0; key_dir = 4'b0000;
    repeat (3) @(negedge clock);
    check("reset player_x", int'(player_x), 75);
    check("reset player_y", int'(player_y), 100);
    check("reset direction", int'(direction), 0);
    check("reset x_out", int'(x_out), 0);
    check("reset y_out", int'(y_out), 0);
    check("reset colour", int'(colour), 0);
    check("reset plot", int'(plot), 0);
    check("reset busy", int'(busy), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("disabled busy", int'(busy), 0);
    enable = 1'b1;
    exp_x = 75; exp_y = 100;
    check_draw("initial", 75, 100);

    foreach (vecs[i])
      run_move(vecs[i].key, vecs[i].stop_v, vecs[i].exp_dir, vecs[i].exp_move, 0, vecs[i].name);

    run_move(DIR_RIGHT, 1'b0, DIR_RIGHT, 1'b1, 10, "tick_in_busy");

    for (int i = 0; i < 50; i++) run_move(DIR_UP, 1'b0, DIR_UP, 1'b1, 0, "walk_up");
    for (int i = 0; i < 79; i++) run_move(DIR_RIGHT, 1'b0, DIR_RIGHT, 1'b1, 0, "walk_right");
    check("at right edge x", int'(player_x), 155);
    run_move(DIR_RIGHT, 1'b0, DIR_RIGHT, 1'b0, 0, "edge_right");
    for (int i = 0; i < 155; i++) run_move(DIR_LEFT, 1'b0, DIR_LEFT, 1'b1, 0, "walk_left");
    check("at left edge x", int'(player_x), 0);
    run_move(DIR_LEFT, 1'b0, DIR_LEFT, 1'b0, 0, "edge_left");

    // Respawn in the middle of an erase pass.
    @(negedge clock);
    key_dir = DIR_RIGHT; stop = 1'b0; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    repeat (13) @(negedge clock);
    check("erase in progress", int'(plot), 1);
    respawn = 1'b1;
    @(negedge clock);
    check("respawn plot", int'(plot), 0);
    check("respawn busy", int'(busy), 0);
    check("respawn direction", int'(direction), 0);
    check("respawn player_x", int'(player_x), 75);
    check("respawn player_y", int'(player_y), 100);
    respawn = 1'b0;
    exp_x = 75; exp_y = 100;
    check_draw("after_respawn", 75, 100);

    // A tick while disabled is dropped.
    enable = 1'b0;
    @(negedge clock);
    key_dir = DIR_RIGHT; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (busy === 1'b1 || plot === 1'b1) nbusy++;
    end
    check("disabled tick activity", nbusy, 0);
    $display("seq  disabled_tick   activity_cycles=%0d", nbusy);
    enable = 1'b1;
    run_move(DIR_RIGHT, 1'b0, DIR_RIGHT, 1'b1, 0, "after_enable");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
